// File: rtl/me_block_scheduler.sv
// Frame sequencer for the motion-estimation core: walks the block grid in raster order,
// runs one search per block and queues results in a small FIFO. Define ME_STATS_EN for frame statistics.
module me_block_scheduler #(
    parameter int BLOCKS_X       = 4,
    parameter int BLOCKS_Y       = 4,
    parameter int TIMEOUT_CYCLES = 4200,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        frame_start,
    output logic        frame_busy,
    output logic        frame_done,
    output logic [3:0]  blk_x,
    output logic [3:0]  blk_y,
    output logic        me_start,
    input  logic        me_completed,
    input  logic [7:0]  me_best_dist,
    input  logic [3:0]  me_motion_x,
    input  logic [3:0]  me_motion_y,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [23:0] res_data,
    output logic        err_timeout
`ifdef ME_STATS_EN
    ,
    output logic [15:0] frame_sad_sum,
    output logic [7:0]  perfect_count
`endif
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0]    LAST_X      = 4'(BLOCKS_X - 1);
    localparam logic [3:0]    LAST_Y      = 4'(BLOCKS_Y - 1);
    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] DEPTH_VAL   = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_RUN, S_CAPTURE, S_GAP, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    blk_x_q, blk_x_d, blk_y_q, blk_y_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [23:0]   hold_q, hold_d;
    logic          err_q, err_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [23:0]   mem_q [FIFO_DEPTH];
    logic          push, pop, fifo_full, last_blk, start_acc;

    assign fifo_full = (count_q == DEPTH_VAL);
    assign pop       = (count_q != '0) && res_ready;
    assign last_blk  = (blk_x_q == LAST_X) && (blk_y_q == LAST_Y);
    assign start_acc = (state_q == S_IDLE) && frame_start;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        state_d = state_q;
        blk_x_d = blk_x_q;
        blk_y_d = blk_y_q;
        tmo_d   = tmo_q;
        hold_d  = hold_q;
        err_d   = err_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_LAUNCH;
                    blk_x_d = '0;
                    blk_y_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_LAUNCH: begin
                tmo_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                tmo_d = tmo_q + TW'(1);
                // A completion arriving on the timeout cycle still counts as a real result.
                if (me_completed) begin
                    hold_d  = {blk_y_q, blk_x_q, me_best_dist, me_motion_x, me_motion_y};
                    state_d = S_CAPTURE;
                end else if (tmo_q == TIMEOUT_VAL) begin
                    hold_d  = {blk_y_q, blk_x_q, 8'hFF, 8'h00};
                    err_d   = 1'b1;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (!fifo_full || pop) begin
                    push    = 1'b1;
                    state_d = last_blk ? S_DONE : S_GAP;
                end
            end
            S_GAP: begin
                if (blk_x_q == LAST_X) begin
                    blk_x_d = '0;
                    blk_y_d = blk_y_q + 4'd1;
                end else begin
                    blk_x_d = blk_x_q + 4'd1;
                end
                state_d = S_LAUNCH;
            end
            S_DONE: begin
                blk_x_d = '0;
                blk_y_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            state_q  <= S_IDLE;
            blk_x_q  <= '0;
            blk_y_q  <= '0;
            tmo_q    <= '0;
            hold_q   <= '0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            blk_x_q  <= blk_x_d;
            blk_y_q  <= blk_y_d;
            tmo_q    <= tmo_d;
            hold_q   <= hold_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: the FIFO storage is reset because res_data must read zero out of reset; it is only a few words.
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= hold_q;
        end
    end

    assign me_start    = (state_q == S_LAUNCH) || (state_q == S_RUN);
    assign frame_busy  = me_start || (state_q == S_CAPTURE) || (state_q == S_GAP);
    assign frame_done  = (state_q == S_DONE);
    assign blk_x       = blk_x_q;
    assign blk_y       = blk_y_q;
    assign res_valid   = (count_q != '0);
    assign res_data    = mem_q[rd_ptr_q];
    assign err_timeout = err_q;

`ifdef ME_STATS_EN
    logic [15:0] sad_q, sad_d;
    logic [7:0]  perf_q, perf_d;
    logic [16:0] sad_sum;

    always_comb begin
        sad_d   = sad_q;
        perf_d  = perf_q;
        sad_sum = {1'b0, sad_q} + {9'b0, hold_q[15:8]};
        if (start_acc) begin
            sad_d  = '0;
            perf_d = '0;
        end else if (push) begin
            sad_d = sad_sum[16] ? 16'hFFFF : sad_sum[15:0];
            // Timeout entries carry 0xFF, so a zero distance is always a genuine match.
            if ((hold_q[15:8] == 8'h00) && (perf_q != 8'hFF)) perf_d = perf_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sad_q  <= '0;
            perf_q <= '0;
        end else begin
            sad_q  <= sad_d;
            perf_q <= perf_d;
        end
    end

    assign frame_sad_sum = sad_q;
    assign perfect_count = perf_q;
`endif

endmodule
